p_hit_2: RTL and testbench

- Stage directly downstream of p_hit_1 in the ray/triangle hit pipeline.
- Consumes the signed Q16 ray parameter t from p_hit_1's output FIFO.
- Pairs each t, in order, with the matching ray (origin, dir) from its own input FIFO.
- Computes the hit point P = origin + t*dir and a front-hit flag, and buffers the results in an output FIFO for the barycentric/inside-test stage.

---
 rtl/p_hit_2_if.sv | 29 ++
 rtl/p_hit_2.sv | 130 +++++++++++++
 tb/tb_p_hit_2.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p_hit_2_if.sv
// p_hit_2_if: bus bundle for the p_hit_2 hit-point stage.
//   t side   : t_in / t_empty (FWFT head of the upstream t FIFO), t_rd_en pops it.
//   ray side : origin / dir pushed with in_wr_en, in_full reports back-pressure.
//   out side : out / out_hit valid while !out_empty, out_rd_en pops the head.
// Vectors are [x,y,z] = [0],[1],[2], each a signed Q16 word.
// master = the environment around the stage, slave = the stage itself.
interface p_hit_2_if;
  logic [31:0]      t_in;
  logic             t_empty;
  logic             t_rd_en;
  logic [2:0][31:0] origin;
  logic [2:0][31:0] dir;
  logic             in_wr_en;
  logic             in_full;
  logic [2:0][31:0] out;
  logic             out_hit;
  logic             out_rd_en;
  logic             out_empty;

  modport master (
    output t_in, t_empty, origin, dir, in_wr_en, out_rd_en,
    input  t_rd_en, in_full, out, out_hit, out_empty
  );

  modport slave (
    input  t_in, t_empty, origin, dir, in_wr_en, out_rd_en,
    output t_rd_en, in_full, out, out_hit, out_empty
  );
endinterface

// File: rtl/p_hit_2.sv
// p_hit_2: pairs each ray parameter t with the next buffered ray and emits
// the hit point P = origin + t*dir (Q16) plus a front-hit flag (t > 0).
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high; drops all buffered and in-flight data
//   bus    - p_hit_2_if.slave: t input, ray push, result FIFO head/pop
// Datapath: issue cycle -> S1 products (64-bit) -> S2 shift/add written
// straight into the result FIFO, so a result is visible two edges after issue.
module p_hit_2 #(
  parameter int Q_BITS         = 16,
  parameter int RAY_FIFO_DEPTH = 16,
  parameter int OUT_FIFO_DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  p_hit_2_if.slave  bus
);
  localparam int RAW = $clog2(RAY_FIFO_DEPTH);
  localparam int OAW = $clog2(OUT_FIFO_DEPTH);

  // ray FIFO: {dir, origin} per entry, read combinationally as the head
  logic [191:0]     ray_mem [RAY_FIFO_DEPTH];
  logic [RAW:0]     ray_wr_ptr_reg;
  logic [RAW:0]     ray_rd_ptr_reg;
  logic             ray_empty;
  logic             ray_full;
  logic             ray_push;
  logic [2:0][31:0] head_origin;
  logic [2:0][31:0] head_dir;

  // result FIFO: {hit, P} per entry
  logic [96:0]      out_mem [OUT_FIFO_DEPTH];
  logic [OAW:0]     out_wr_ptr_reg;
  logic [OAW:0]     out_rd_ptr_reg;
  logic [OAW:0]     out_count;
  logic [OAW:0]     credit_reg;
  logic [OAW+1:0]   committed;
  logic             out_empty;
  logic             out_pop;
  logic             out_push;
  logic [96:0]      out_head;

  logic             issue;
  logic             s1_valid_reg;
  logic             s1_hit_reg;
  logic [2:0][31:0] s1_origin_reg;
  logic [2:0][31:0] s2_point;

  // extra pointer MSB distinguishes full from empty
  assign ray_empty = (ray_wr_ptr_reg == ray_rd_ptr_reg);
  assign ray_full  = (ray_wr_ptr_reg[RAW] != ray_rd_ptr_reg[RAW]) &&
                     (ray_wr_ptr_reg[RAW-1:0] == ray_rd_ptr_reg[RAW-1:0]);
  assign ray_push  = bus.in_wr_en && !ray_full;
  assign {head_dir, head_origin} = ray_mem[ray_rd_ptr_reg[RAW-1:0]];

  assign out_count = out_wr_ptr_reg - out_rd_ptr_reg;
  assign out_empty = (out_wr_ptr_reg == out_rd_ptr_reg);
  assign out_pop   = bus.out_rd_en && !out_empty;
  assign out_push  = s1_valid_reg;

  // Reserve a result slot at issue time: buffered + in-flight may never
  // exceed the FIFO depth, so the pipeline never has to stall or drop.
  assign committed = {1'b0, out_count} + {1'b0, credit_reg};
  assign issue     = !reset && !bus.t_empty && !ray_empty &&
                     (committed < (OAW+2)'(OUT_FIFO_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      ray_wr_ptr_reg <= '0;
      ray_rd_ptr_reg <= '0;
    end else begin
      if (ray_push) ray_wr_ptr_reg <= ray_wr_ptr_reg + (RAW+1)'(1);
      if (issue)    ray_rd_ptr_reg <= ray_rd_ptr_reg + (RAW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (ray_push && !reset) ray_mem[ray_wr_ptr_reg[RAW-1:0]] <= {bus.dir, bus.origin};
  end

  // S1 control and carried fields
  always_ff @(posedge clock) begin
    if (reset) s1_valid_reg <= 1'b0;
    else       s1_valid_reg <= issue;
  end

  always_ff @(posedge clock) begin
    if (issue) begin
      s1_origin_reg <= head_origin;
      s1_hit_reg    <= ($signed(bus.t_in) > 0);
    end
  end

  // per-axis multiply (S1) and floor-shift + wrapping add (S2)
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic signed [63:0] prod_reg;
    logic signed [63:0] shifted;

    always_ff @(posedge clock) begin
      if (issue) prod_reg <= 64'($signed(head_dir[gi])) * 64'($signed(bus.t_in));
    end

    assign shifted      = prod_reg >>> Q_BITS;
    assign s2_point[gi] = s1_origin_reg[gi] + shifted[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      credit_reg     <= '0;
    end else begin
      if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + (OAW+1)'(1);
      if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + (OAW+1)'(1);
      credit_reg <= credit_reg + (OAW+1)'(issue) - (OAW+1)'(out_push);
    end
  end

  always_ff @(posedge clock) begin
    if (out_push && !reset) out_mem[out_wr_ptr_reg[OAW-1:0]] <= {s1_hit_reg, s2_point};
  end

  assign out_head      = out_mem[out_rd_ptr_reg[OAW-1:0]];
  // gate the head so an empty FIFO always shows zeros
  assign bus.out       = out_empty ? '0 : out_head[95:0];
  assign bus.out_hit   = !out_empty && out_head[96];
  assign bus.out_empty = out_empty;
  assign bus.in_full   = ray_full;
  assign bus.t_rd_en   = issue;
endmodule

// File: tb/tb_p_hit_2.sv
// tb_p_hit_2: directed bench for p_hit_2. Drives inputs at the falling edge,
// samples outputs just before the rising edge, and keeps a queue model of
// the t FIFO, ray FIFO and result FIFO to check ordering and flags.
module tb_p_hit_2;
  logic clock = 1'b0;
  logic reset;

  p_hit_2_if bus ();

  p_hit_2 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int popped     = 0;
  int issued_cnt = 0;
  bit pend_v     = 1'b0;
  bit last_wr    = 1'b0;
  logic [96:0]  pend;
  logic [31:0]  t_q   [$];
  logic [191:0] ray_q [$];
  logic [96:0]  out_q [$];

  logic [2:0][31:0] bo [20];
  logic [2:0][31:0] bd [20];
  logic [31:0]      bt [20];

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // reference: P_k = origin_k + floor(dir_k * t / 2^16), wrapped to 32 bits
  function automatic logic [96:0] ref_res(input logic [95:0] o, input logic [95:0] d,
                                          input logic [31:0] t);
    logic signed [63:0] p;
    logic [96:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      p = 64'($signed(d[k*32 +: 32])) * 64'($signed(t));
      p = p >>> 16;
      r[k*32 +: 32] = o[k*32 +: 32] + p[31:0];
    end
    r[96] = ($signed(t) > 0);
    return r;
  endfunction

  task automatic refresh_t();
    bus.t_empty = (t_q.size() == 0);
    bus.t_in    = (t_q.size() != 0) ? t_q[0] : 32'h0;
  endtask

  task automatic push_t(input logic [31:0] t);
    t_q.push_back(t);
    refresh_t();
  endtask

  // one clock: called at a falling edge, returns at the next falling edge
  task automatic cyc();
    logic rst, exp_iss, rd, wr;
    logic [191:0] ray_in;
    #4;
    rst     = reset;
    exp_iss = !rst && (t_q.size() > 0) && (ray_q.size() > 0) &&
              ((out_q.size() + (pend_v ? 1 : 0)) < 16);
    chk1("t_rd_en", bus.t_rd_en, exp_iss);
    if (!rst) begin
      chk1("out_empty", bus.out_empty, out_q.size() == 0);
      chk1("in_full", bus.in_full, ray_q.size() == 16);
    end
    rd = !rst && bus.out_rd_en && (out_q.size() > 0);
    if (rd) begin
      chk32("pop_x", bus.out[0], out_q[0][31:0]);
      chk32("pop_y", bus.out[1], out_q[0][63:32]);
      chk32("pop_z", bus.out[2], out_q[0][95:64]);
      chk1("pop_hit", bus.out_hit, out_q[0][96]);
    end
    wr     = !rst && bus.in_wr_en && (ray_q.size() < 16);
    ray_in = {bus.dir, bus.origin};
    if (bus.t_rd_en) issued_cnt++;
    @(posedge clock);
    @(negedge clock);
    if (rst) begin
      t_q.delete();
      ray_q.delete();
      out_q.delete();
      pend_v = 1'b0;
    end else begin
      if (rd) begin
        void'(out_q.pop_front());
        popped++;
      end
      if (pend_v) out_q.push_back(pend);
      pend_v = exp_iss;
      if (exp_iss) begin
        pend = ref_res(ray_q[0][95:0], ray_q[0][191:96], t_q[0]);
        void'(t_q.pop_front());
        void'(ray_q.pop_front());
      end
      if (wr) ray_q.push_back(ray_in);
    end
    last_wr = wr;
    refresh_t();
  endtask

  task automatic check_head(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                            input logic [31:0] ez, input logic eh);
    chk32({tag, "_x"}, bus.out[0], ex);
    chk32({tag, "_y"}, bus.out[1], ey);
    chk32({tag, "_z"}, bus.out[2], ez);
    chk1({tag, "_hit"}, bus.out_hit, eh);
  endtask

  // single ray through an idle stage, with hand-computed expected result
  task automatic run_one(input string tag, input logic [2:0][31:0] o, input logic [2:0][31:0] d,
                         input logic [31:0] t, input logic [31:0] ex, input logic [31:0] ey,
                         input logic [31:0] ez, input logic eh);
    bus.origin   = o;
    bus.dir      = d;
    bus.in_wr_en = 1'b1;
    push_t(t);
    cyc();
    bus.in_wr_en = 1'b0;
    chk1({tag, "_issue"}, bus.t_rd_en, 1'b1);
    cyc();
    chk1({tag, "_lat1_empty"}, bus.out_empty, 1'b1);
    cyc();
    chk1({tag, "_lat2_empty"}, bus.out_empty, 1'b0);
    check_head(tag, ex, ey, ez, eh);
    $display("ray %s: out=(%h,%h,%h) hit=%b", tag, bus.out[0], bus.out[1], bus.out[2], bus.out_hit);
    bus.out_rd_en = 1'b1;
    cyc();
    bus.out_rd_en = 1'b0;
    chk1({tag, "_drained"}, bus.out_empty, 1'b1);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    bus.in_wr_en  = 1'b0;
    bus.out_rd_en = 1'b0;
    bus.origin    = '0;
    bus.dir       = '0;
    refresh_t();
    @(negedge clock);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk1("rst_out_empty", bus.out_empty, 1'b1);
    chk1("rst_in_full", bus.in_full, 1'b0);
    chk1("rst_t_rd_en", bus.t_rd_en, 1'b0);
    chk32("rst_out_x", bus.out[0], 32'h0);
    chk1("rst_out_hit", bus.out_hit, 1'b0);

    // popping an empty result FIFO has no effect
    bus.out_rd_en = 1'b1;
    cyc();
    bus.out_rd_en = 1'b0;
    chk1("empty_pop", bus.out_empty, 1'b1);

    run_one("single", {32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h00010000}, 32'h00020000,
            32'h00020000, 32'h0, 32'h0, 1'b1);
    run_one("negdir", {32'h00010000, 32'h00010000, 32'h00010000},
            {32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000}, 32'h00040000,
            32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 1'b1);
    run_one("behind", {32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h00010000}, 32'hFFFF0000,
            32'hFFFF0000, 32'h0, 32'h0, 1'b0);
    run_one("t_zero", {32'h0, 32'h12345678, 32'h00030000},
            {32'h00010000, 32'h00010000, 32'h00010000}, 32'h0,
            32'h00030000, 32'h12345678, 32'h0, 1'b0);
    // floor rounding: -1/65536 -> -1, -1.5 -> -2
    run_one("floor", {32'h0, 32'h0, 32'h0}, {32'h0, 32'h00018000, 32'h00000001}, 32'hFFFFFFFF,
            32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 1'b0);
    run_one("wrap", {32'h0, 32'h0, 32'h7FFF0000}, {32'h0, 32'h0, 32'h00010000}, 32'h00020000,
            32'h80010000, 32'h0, 32'h0, 1'b1);

    // back-pressure: 20 rays / 20 t with the result FIFO never popped
    for (int i = 0; i < 20; i++) begin
      bo[i] = {$urandom(), $urandom(), $urandom()};
      bd[i] = {$urandom(), $urandom(), $urandom()};
      bt[i] = $urandom();
      push_t(bt[i]);
    end
    issued_cnt = 0;
    n = 0;
    for (int c = 0; c < 100 && n < 20; c++) begin
      bus.origin   = bo[n];
      bus.dir      = bd[n];
      bus.in_wr_en = 1'b1;
      cyc();
      if (last_wr) n++;
    end
    bus.in_wr_en = 1'b0;
    chk32("bp_rays_pushed", n, 20);
    repeat (10) cyc();
    chk32("bp_issued", issued_cnt, 16);
    chk1("bp_stalled", bus.t_rd_en, 1'b0);
    chk1("bp_buffered", bus.out_empty, 1'b0);
    $display("backpressure: issued=%0d while output held", issued_cnt);
    popped = 0;
    bus.out_rd_en = 1'b1;
    for (int c = 0; c < 200 && popped < 20; c++) cyc();
    bus.out_rd_en = 1'b0;
    chk32("bp_drained", popped, 20);
    chk1("bp_empty", bus.out_empty, 1'b1);
    $display("backpressure: drained=%0d results", popped);

    // ray FIFO overflow with no t available
    for (int i = 0; i < 17; i++) begin
      bus.origin   = {32'h0, 32'h0, 32'(i) << 16};
      bus.dir      = {32'h0, 32'h0, 32'h00010000};
      bus.in_wr_en = 1'b1;
      cyc();
      if (i == 15) chk1("ovf_full_16", bus.in_full, 1'b1);
    end
    bus.in_wr_en = 1'b0;
    chk1("ovf_full_17", bus.in_full, 1'b1);
    popped = 0;
    bus.out_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) push_t(32'h00010000);
    for (int c = 0; c < 100 && popped < 16; c++) cyc();
    chk32("ovf_drained", popped, 16);
    // the 17th ray must be gone: a spare t finds no partner
    push_t(32'h00010000);
    repeat (4) cyc();
    chk1("ovf_no_17th", bus.t_rd_en, 1'b0);
    chk1("ovf_out_empty", bus.out_empty, 1'b1);
    bus.out_rd_en = 1'b0;
    t_q.delete();
    refresh_t();
    $display("overflow: drained=%0d, 17th ray dropped", popped);

    // reset with results buffered and in flight
    for (int i = 0; i < 8; i++) push_t(32'h00010000);
    n = 0;
    for (int c = 0; c < 50 && out_q.size() < 5; c++) begin
      bus.origin   = {32'h0, 32'h0, 32'(c) << 16};
      bus.dir      = {32'h0, 32'h0, 32'h00010000};
      bus.in_wr_en = 1'b1;
      cyc();
      n++;
    end
    chk1("mid_buffered", bus.out_empty, 1'b0);
    reset         = 1'b1;
    bus.out_rd_en = 1'b1;
    cyc();
    reset         = 1'b0;
    bus.in_wr_en  = 1'b0;
    bus.out_rd_en = 1'b0;
    chk1("mid_out_empty", bus.out_empty, 1'b1);
    chk1("mid_in_full", bus.in_full, 1'b0);
    chk1("mid_t_rd_en", bus.t_rd_en, 1'b0);
    repeat (3) cyc();
    chk1("mid_no_stale", bus.out_empty, 1'b1);
    $display("reset mid-stream after %0d cycles of loading", n);
    run_one("fresh", {32'h00000004, 32'h00000002, 32'h00010000},
            {32'h00030000, 32'hFFFE0000, 32'h00010000}, 32'h00008000,
            32'h00018000, 32'hFFFF0002, 32'h00018004, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
